mem_arbiter: RTL and testbench

Two-master arbiter that shares the single picorv32-style memory port between the `riscv` core (master 0) and a second requester such as a loader or debug/DMA engine (master 1). It sits between the masters and the memory/bus. It holds one grant for the full duration of a transaction, and alternates the grant round-robin when both masters contend. A watchdog ends any transaction the memory never acknowledges and returns an error to the granted master, so a dead slave cannot hang the core.

---
 rtl/mem_arbiter_pkg.sv | 37 +++
 rtl/mem_arbiter_picker.sv | 28 ++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 524 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the two-master memory arbiter
// and for future bus blocks that reuse the request bundle.
package mem_arbiter_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    // A lone requester always wins; a tie goes to the other master
    // than last time, or to master 0 in fixed-priority mode.
    function automatic logic pick_winner(
        input logic [NUM_MASTERS-1:0] valid,
        input logic                   last,
        input logic                   rr
    );
        logic w;
        w = 1'b0;
        unique case (1'b1)
            (&valid):         w = rr ? ~last : 1'b0;
            (valid == 2'b10): w = 1'b1;
            default:          w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter_picker.sv
// rr_picker: chooses the next owner of the memory port and
// remembers the last owner for round-robin fairness.
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] valid,
    input  logic                   capture,
    output logic                   winner
);

    logic last_grant;

    assign winner = pick_winner(valid, last_grant, ROUND_ROBIN);

    // Reset value 1 makes the first contended grant go to master 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (capture) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one picorv32-style memory port between two
// masters, holding each grant for a whole transaction with a watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_MASTERS-1:0]       m_valid,
    input  logic [NUM_MASTERS-1:0]       m_instr,
    input  logic [NUM_MASTERS-1:0][31:0] m_addr,
    input  logic [NUM_MASTERS-1:0][31:0] m_wdata,
    input  logic [NUM_MASTERS-1:0][3:0]  m_wstrb,
    output logic [NUM_MASTERS-1:0]       m_ready,
    output logic [31:0]                  m_rdata,
    output logic                         m_error,
    output logic                         mem_valid,
    output logic                         mem_instr,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [3:0]                   mem_wstrb,
    input  logic                         mem_ready,
    input  logic [31:0]                  mem_rdata,
    output logic                         grant
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t      state;
    mem_req_t        req;
    logic [WD_W-1:0] wd_cnt;
    logic            winner;
    logic            capture;
    logic            done;
    logic            expired;

    assign capture = (state == ARB_IDLE) && (|m_valid);
    assign done    = (state == ARB_BUSY) && mem_ready;
    // A late acknowledge in the final cycle still counts as success.
    assign expired = (state == ARB_BUSY) && !mem_ready
                     && (wd_cnt == WD_LAST);

    rr_picker #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_picker (
        .clk     (clk),
        .reset   (reset),
        .valid   (m_valid),
        .capture (capture),
        .winner  (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ARB_IDLE;
            req    <= '0;
            wd_cnt <= '0;
            grant  <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (capture) begin
                        req.valid <= 1'b1;
                        req.instr <= m_instr[winner];
                        req.addr  <= m_addr[winner];
                        req.wdata <= m_wdata[winner];
                        req.wstrb <= m_wstrb[winner];
                        grant     <= winner;
                        wd_cnt    <= '0;
                        state     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (done || expired) begin
                        req.valid <= 1'b0;
                        state     <= ARB_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        m_ready = '0;
        m_rdata = '0;
        m_error = 1'b0;
        if (done) begin
            m_ready[grant] = 1'b1;
            m_rdata        = mem_rdata;
        end else if (expired) begin
            m_ready[grant] = 1'b1;
            m_error        = 1'b1;
        end
    end

    assign mem_valid = req.valid;
    assign mem_instr = req.instr;
    assign mem_addr  = req.addr;
    assign mem_wdata = req.wdata;
    assign mem_wstrb = req.wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int TO_A = 8;
    localparam int TO_B = 16;

    logic             clk;
    logic             reset;
    logic [1:0]       m_valid;
    logic [1:0]       m_instr;
    logic [1:0][31:0] m_addr;
    logic [1:0][31:0] m_wdata;
    logic [1:0][3:0]  m_wstrb;

    logic [1:0]  a_m_ready, b_m_ready;
    logic [31:0] a_m_rdata, b_m_rdata;
    logic        a_m_error, b_m_error;
    logic        a_mem_valid, b_mem_valid;
    logic        a_mem_instr, b_mem_instr;
    logic [31:0] a_mem_addr, b_mem_addr;
    logic [31:0] a_mem_wdata, b_mem_wdata;
    logic [3:0]  a_mem_wstrb, b_mem_wstrb;
    logic        a_mem_ready, b_mem_ready;
    logic [31:0] a_mem_rdata, b_mem_rdata;
    logic        a_grant, b_grant;

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-priority instance always sees a zero-wait memory.
    assign b_mem_ready = b_mem_valid;
    assign b_mem_rdata = b_mem_addr ^ 32'h5A5A_5A5A;

    mem_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(a_m_ready), .m_rdata(a_m_rdata), .m_error(a_m_error),
        .mem_valid(a_mem_valid), .mem_instr(a_mem_instr),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_wstrb(a_mem_wstrb), .mem_ready(a_mem_ready),
        .mem_rdata(a_mem_rdata), .grant(a_grant)
    );

    mem_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(b_m_ready), .m_rdata(b_m_rdata), .m_error(b_m_error),
        .mem_valid(b_mem_valid), .mem_instr(b_mem_instr),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_wstrb(b_mem_wstrb), .mem_ready(b_mem_ready),
        .mem_rdata(b_mem_rdata), .grant(b_grant)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        m_valid = 2'b00;
        a_mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        m_valid = 2'b11;
        a_mem_ready = 1'b1;
        a_mem_rdata = $urandom;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            tests++;
            if ({a_mem_valid, a_mem_instr, a_mem_addr, a_mem_wdata,
                 a_mem_wstrb} !== '0) begin
                fails++;
                $display("FAIL reset_mem: got %h want 0",
                         {a_mem_valid, a_mem_instr, a_mem_addr,
                          a_mem_wdata, a_mem_wstrb});
            end
            tests++;
            if ({a_m_ready, a_m_error, a_m_rdata, a_grant} !== '0) begin
                fails++;
                $display("FAIL reset_resp: got %h want 0",
                         {a_m_ready, a_m_error, a_m_rdata, a_grant});
            end
        end
        @(negedge clk);
        m_valid = 2'b00;
        a_mem_ready = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_single();
        int hi = 0;
        int r0 = 0;
        int r1 = 0;
        do_reset();
        @(negedge clk);
        m_instr = 2'b00;
        m_addr[0] = 32'h100;
        m_wstrb[0] = 4'h0;
        m_wdata[0] = $urandom;
        m_valid = 2'b01;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            a_mem_ready = a_mem_valid && (hi == 3);
            a_mem_rdata = a_mem_ready ? 32'hDEAD_BEEF : $urandom;
            #1;
            if (a_mem_valid) begin
                hi++;
                tests++;
                if (a_mem_addr !== 32'h100 || a_mem_wstrb !== 4'h0) begin
                    fails++;
                    $display("FAIL single_fields: got %h/%h want 100/0",
                             a_mem_addr, a_mem_wstrb);
                end
            end
            if (a_m_ready[0]) begin
                r0++;
                tests++;
                if (a_m_rdata !== 32'hDEAD_BEEF || a_m_error !== 1'b0) begin
                    fails++;
                    $display("FAIL single_rdata: got %h err %b want deadbeef",
                             a_m_rdata, a_m_error);
                end
                m_valid[0] = 1'b0;
            end
            if (a_m_ready[1]) r1++;
        end
        a_mem_ready = 1'b0;
        tests++;
        if (hi != 4 || r0 != 1 || r1 != 0) begin
            fails++;
            $display("FAIL single_counts: got hi=%0d r0=%0d r1=%0d want 4 1 0",
                     hi, r0, r1);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int raise = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == raise) m_valid[0] = 1'b1;
            a_mem_ready = a_mem_valid;
            a_mem_rdata = $urandom;
            #1;
            if (a_m_ready[0]) begin
                tests++;
                if (c != 1 + 3 * n) begin
                    fails++;
                    $display("FAIL b2b_cycle: got %0d want %0d", c, 1 + 3 * n);
                end
                n++;
                m_valid[0] = 1'b0;
                raise = c + 2;
            end
        end
        a_mem_ready = 1'b0;
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL b2b_count: got %0d want 4", n);
        end
    endtask

    task automatic test_contention();
        int n = 0;
        bit rr[2];
        logic [1:0] exp;
        rr = '{1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            if (c == 0) m_valid = 2'b11;
            for (int i = 0; i < 2; i++)
                if (rr[i]) begin
                    m_valid[i] = 1'b1;
                    rr[i] = 1'b0;
                end
            a_mem_ready = a_mem_valid;
            a_mem_rdata = $urandom;
            #1;
            if (a_m_ready != 2'b00) begin
                exp = 2'b01 << (n % 2);
                tests++;
                if (a_m_ready !== exp || a_grant !== exp[1]) begin
                    fails++;
                    $display("FAIL contention_order: got %b/%b want %b/%b",
                             a_m_ready, a_grant, exp, exp[1]);
                end
                m_valid[n % 2] = 1'b0;
                rr[n % 2] = 1'b1;
                n++;
            end
        end
        m_valid = 2'b00;
        a_mem_ready = 1'b0;
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL contention_count: got %0d want 4", n);
        end
    endtask

    task automatic test_no_rr();
        int n = 0;
        bit again = 1'b0;
        logic [1:0] exp;
        do_reset();
        for (int c = 0; c < 30 && n < 5; c++) begin
            @(negedge clk);
            if (c == 0) m_valid = 2'b11;
            if (again) begin
                m_valid[0] = 1'b1;
                again = 1'b0;
            end
            #1;
            if (b_m_ready != 2'b00) begin
                exp = (n < 4) ? 2'b01 : 2'b10;
                tests++;
                if (b_m_ready !== exp || b_m_error !== 1'b0) begin
                    fails++;
                    $display("FAIL norr_order: got %b want %b (n=%0d)",
                             b_m_ready, exp, n);
                end
                if (b_m_ready[0]) begin
                    m_valid[0] = 1'b0;
                    again = (n < 3);
                end
                if (b_m_ready[1]) m_valid[1] = 1'b0;
                n++;
            end
        end
        m_valid = 2'b00;
        tests++;
        if (n != 5) begin
            fails++;
            $display("FAIL norr_count: got %0d want 5", n);
        end
    endtask

    task automatic test_watchdog();
        int hi;
        bit done;
        logic [31:0] d;
        for (int k = 0; k < 2; k++) begin
            hi = 0;
            done = 1'b0;
            do_reset();
            @(negedge clk);
            m_addr[0] = $urandom;
            m_wstrb[0] = 4'hF;
            m_valid = 2'b01;
            for (int c = 0; c < 20 && !done; c++) begin
                if (c > 0) @(negedge clk);
                d = $urandom;
                a_mem_ready = (k == 1) && a_mem_valid && (hi == TO_A - 1);
                a_mem_rdata = d;
                #1;
                if (a_mem_valid) hi++;
                if (a_m_ready != 2'b00) begin
                    done = 1'b1;
                    tests++;
                    if (hi != TO_A || a_m_ready !== 2'b01
                        || a_m_error !== (k == 0)
                        || a_m_rdata !== ((k == 0) ? 32'h0 : d)) begin
                        fails++;
                        $display("FAIL watchdog_%0d: got cyc=%0d rdy=%b err=%b rd=%h want cyc=%0d rdy=01 err=%b rd=%h",
                                 k, hi, a_m_ready, a_m_error, a_m_rdata,
                                 TO_A, (k == 0), (k == 0) ? 32'h0 : d);
                    end
                    m_valid[0] = 1'b0;
                end
            end
            tests++;
            if (!done) begin
                fails++;
                $display("FAIL watchdog_wait_%0d: got no m_ready want one", k);
            end
            @(posedge clk);
            #1;
            a_mem_ready = 1'b0;
            tests++;
            if (a_mem_valid !== 1'b0) begin
                fails++;
                $display("FAIL watchdog_drop_%0d: got mem_valid %b want 0",
                         k, a_mem_valid);
            end
        end
    endtask

    task automatic test_write();
        do_reset();
        @(negedge clk);
        m_addr[0] = 32'hAAAA_0000;
        m_wdata[0] = 32'h5555;
        m_wstrb[0] = 4'hC;
        m_instr = 2'b01;
        m_addr[1] = 32'h2000;
        m_wdata[1] = 32'h1234;
        m_wstrb[1] = 4'b0011;
        m_valid = 2'b10;
        a_mem_ready = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if ({a_mem_valid, a_mem_instr, a_mem_addr, a_mem_wdata,
             a_mem_wstrb, a_grant}
            !== {1'b1, 1'b0, 32'h2000, 32'h1234, 4'b0011, 1'b1}) begin
            fails++;
            $display("FAIL write_fields: got %b %b %h %h %b %b want 1 0 2000 1234 0011 1",
                     a_mem_valid, a_mem_instr, a_mem_addr, a_mem_wdata,
                     a_mem_wstrb, a_grant);
        end
        m_wdata[1] = 32'hFFFF_FFFF;
        m_addr[1] = 32'h3000;
        @(negedge clk);
        a_mem_ready = 1'b1;
        #1;
        tests++;
        if (a_mem_wdata !== 32'h1234 || a_mem_addr !== 32'h2000) begin
            fails++;
            $display("FAIL write_hold: got %h/%h want 1234/2000",
                     a_mem_wdata, a_mem_addr);
        end
        tests++;
        if (a_m_ready !== 2'b10 || a_m_error !== 1'b0) begin
            fails++;
            $display("FAIL write_ready: got %b/%b want 10/0",
                     a_m_ready, a_m_error);
        end
        m_valid = 2'b00;
        @(negedge clk);
        a_mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        m_addr[0] = 32'h0000_1110;
        m_addr[1] = 32'h0000_2220;
        m_valid = 2'b01;
        a_mem_ready = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (a_mem_valid !== 1'b1 || a_grant !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_busy: got %b/%b want 1/0",
                     a_mem_valid, a_grant);
        end
        #1;
        reset = 1'b0;
        #1;
        tests++;
        if (a_mem_valid !== 1'b0 || a_m_ready !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_abort: got %b/%b want 0/00",
                     a_mem_valid, a_m_ready);
        end
        @(negedge clk);
        m_valid = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        m_valid = 2'b11;
        @(negedge clk);
        #1;
        tests++;
        if (a_mem_valid !== 1'b1 || a_grant !== 1'b0
            || a_mem_addr !== 32'h0000_1110) begin
            fails++;
            $display("FAIL rstmid_regrant: got %b/%b/%h want 1/0/00001110",
                     a_mem_valid, a_grant, a_mem_addr);
        end
        m_valid = 2'b00;
    endtask

    task automatic test_random();
        bit          busy;
        logic        owner;
        logic        last;
        int          wcnt;
        int          lat;
        int          gap[2];
        bit          pend[2];
        logic [31:0] raddr[2];
        logic [31:0] rwdata[2];
        logic [3:0]  rwstrb[2];
        logic        rinstr[2];
        logic [31:0] data;
        bit          rdy;
        bit          to;
        logic [1:0]  exp_rdy;
        busy = 1'b0;
        owner = 1'b0;
        last = 1'b1;
        wcnt = 0;
        lat = 0;
        gap = '{0, 0};
        pend = '{1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else if ($urandom_range(0, 3) != 0) begin
                        pend[i] = 1'b1;
                        raddr[i] = $urandom;
                        rwdata[i] = $urandom;
                        rwstrb[i] = 4'($urandom_range(0, 15));
                        rinstr[i] = 1'($urandom_range(0, 1));
                        m_addr[i] = raddr[i];
                        m_wdata[i] = rwdata[i];
                        m_wstrb[i] = rwstrb[i];
                        m_instr[i] = rinstr[i];
                        m_valid[i] = 1'b1;
                    end
                end else if (busy && owner == 1'(i)) begin
                    m_wdata[i] = $urandom;
                end
            end
            data = $urandom;
            rdy = busy && (wcnt == lat);
            to = busy && !rdy && (wcnt == TO_A - 1);
            a_mem_ready = rdy || (!busy && $urandom_range(0, 7) == 0);
            a_mem_rdata = data;
            exp_rdy = 2'b00;
            if (rdy || to) exp_rdy[owner] = 1'b1;
            #1;
            tests++;
            if (a_m_ready !== exp_rdy || a_mem_valid !== busy) begin
                fails++;
                $display("FAIL rand_ready c=%0d: got %b/%b want %b/%b",
                         c, a_m_ready, a_mem_valid, exp_rdy, busy);
            end
            if (busy) begin
                tests++;
                if ({a_mem_addr, a_mem_wdata, a_mem_wstrb, a_mem_instr, a_grant}
                    !== {raddr[owner], rwdata[owner], rwstrb[owner],
                         rinstr[owner], owner}) begin
                    fails++;
                    $display("FAIL rand_fields c=%0d: got %h want %h", c,
                             {a_mem_addr, a_mem_wdata, a_mem_wstrb,
                              a_mem_instr, a_grant},
                             {raddr[owner], rwdata[owner], rwstrb[owner],
                              rinstr[owner], owner});
                end
            end
            if (exp_rdy != 2'b00) begin
                tests++;
                if (a_m_error !== to || a_m_rdata !== (to ? 32'h0 : data)) begin
                    fails++;
                    $display("FAIL rand_resp c=%0d: got %b/%h want %b/%h",
                             c, a_m_error, a_m_rdata, to,
                             to ? 32'h0 : data);
                end
            end
            if (busy) begin
                if (rdy || to) begin
                    busy = 1'b0;
                    pend[owner] = 1'b0;
                    m_valid[owner] = 1'b0;
                    gap[owner] = $urandom_range(0, 2);
                end else begin
                    wcnt++;
                end
            end else if (pend[0] || pend[1]) begin
                if (pend[0] && pend[1]) owner = ~last;
                else owner = pend[1];
                last = owner;
                busy = 1'b1;
                wcnt = 0;
                case ($urandom_range(0, 9))
                    0: lat = TO_A;
                    1: lat = TO_A - 1;
                    default: lat = $urandom_range(0, 3);
                endcase
            end
        end
        @(negedge clk);
        m_valid = 2'b00;
        a_mem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        m_valid = 2'b00;
        m_instr = 2'b00;
        m_addr = '0;
        m_wdata = '0;
        m_wstrb = '0;
        a_mem_ready = 1'b0;
        a_mem_rdata = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        test_no_rr();
        test_watchdog();
        test_write();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench time limit");
    end

endmodule
